// File: rtl/stickman_sprite.sv
`default_nettype none
// ============================================================================
//  Module   : stickman_sprite
//  Purpose  : Runner sprite object. Keeps the runner's top Y using
//             velocity/gravity jump physics (edge-triggered take-off, short
//             hop on early Space release), steps a multi-frame run animation,
//             and produces the per-pixel hit flag from an external
//             synchronous sprite ROM with integer (power-of-two) scaling.
//  Ports    : Clk, Reset (sync, active-low)
//             frame_clk   - ~60 Hz frame clock, resynchronised here
//             keycode     - last key, 8'h2C = Space
//             freeze      - hold all motion and animation
//             DrawX/DrawY - current pixel being drawn
//             rom_addr    - registered sprite ROM address
//             rom_data    - ROM row for the previous cycle's rom_addr
//             is_stickman - pixel hit, one cycle after DrawX/DrawY
//             Stick_Y     - current top Y
//             airborne    - rising or falling
//             anim_frame  - current ROM frame index
//  Revision : 1.0 - initial release
// ============================================================================
module stickman_sprite #(
  parameter int X_POS       = 200,
  parameter int Y_GROUND    = 334,
  parameter int Y_MIN       = 10,
  parameter int WIDTH       = 8,
  parameter int HEIGHT      = 16,
  parameter int SCALE_SHIFT = 0,
  parameter int JUMP_V      = 10,
  parameter int GRAVITY     = 1,
  parameter int V_MAX       = 12,
  parameter int HOP_V       = 2,
  parameter int N_FRAMES    = 4,
  parameter int ANIM_DIV    = 6,
  parameter int ADDR_W      = 7
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [7:0]        keycode,
  input  logic              freeze,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_data,
  output logic              is_stickman,
  output logic [9:0]        Stick_Y,
  output logic              airborne,
  output logic [2:0]        anim_frame
);

  localparam int c_cnt_w = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int c_col_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic signed [10:0] c_y_ground = 11'(Y_GROUND);
  localparam logic signed [10:0] c_y_min    = 11'(Y_MIN);
  localparam logic signed [10:0] c_x_pos    = 11'(X_POS);
  localparam logic signed [10:0] c_w_px     = 11'(WIDTH << SCALE_SHIFT);
  localparam logic signed [10:0] c_h_px     = 11'(HEIGHT << SCALE_SHIFT);
  localparam logic signed [7:0]  c_jump_v   = 8'(JUMP_V);
  localparam logic signed [7:0]  c_gravity  = 8'(GRAVITY);
  localparam logic signed [7:0]  c_v_max    = 8'(V_MAX);
  localparam logic signed [7:0]  c_hop_v    = 8'(HOP_V);

  typedef enum logic [1:0] {
    S_GROUND = 2'd0,
    S_RISE   = 2'd1,
    S_FALL   = 2'd2
  } state_t;

  // ---------------------------------------------------------------- tick
  logic [1:0] sync_q;
  logic       w_tick, w_step, w_space, w_jump_req;
  logic       space_prev_q;

  // sync_q[0] is the resynchronised frame clock, sync_q[1] its previous value
  assign w_tick     = sync_q[0] & ~sync_q[1];
  assign w_step     = w_tick & ~freeze;
  assign w_space    = (keycode == 8'h2C);
  assign w_jump_req = w_space & ~space_prev_q;

  // ------------------------------------------------------------- physics
  state_t              state_q, state_d;
  logic [9:0]          y_q, y_d;
  logic signed [7:0]   v_q, v_d;
  logic [2:0]          frame_q, frame_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;

  logic signed [7:0]   w_v_eff, w_v_sum, w_v_n;
  logic signed [10:0]  w_y_n;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    v_d     = v_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;

    // Early release while still climbing fast caps the upward speed
    w_v_eff = v_q;
    if (state_q == S_RISE && !w_space && v_q < -c_hop_v)
      w_v_eff = -c_hop_v;
    w_y_n   = $signed({1'b0, y_q}) + $signed({{3{w_v_eff[7]}}, w_v_eff});
    w_v_sum = w_v_eff + c_gravity;
    w_v_n   = (w_v_sum > c_v_max) ? c_v_max : w_v_sum;

    if (w_step) begin
      case (state_q)
        S_GROUND: begin
          if (w_jump_req) begin
            state_d = S_RISE;
            v_d     = -c_jump_v;
            frame_d = 3'(N_FRAMES);
            cnt_d   = '0;
          end else if (cnt_q == c_cnt_w'(ANIM_DIV - 1)) begin
            cnt_d   = '0;
            frame_d = (frame_q == 3'(N_FRAMES - 1)) ? 3'd0 : frame_q + 3'd1;
          end else begin
            cnt_d   = cnt_q + c_cnt_w'(1);
          end
        end
        S_RISE: begin
          if (w_y_n <= c_y_min) begin
            y_d     = 10'(c_y_min);
            v_d     = 8'sd0;
            state_d = S_FALL;
          end else begin
            y_d = w_y_n[9:0];
            v_d = w_v_n;
            if (w_v_n >= 8'sd0)
              state_d = S_FALL;
          end
        end
        S_FALL: begin
          if (w_y_n >= c_y_ground) begin
            y_d     = 10'(c_y_ground);
            v_d     = 8'sd0;
            state_d = S_GROUND;
            frame_d = 3'd0;
            cnt_d   = '0;
          end else begin
            y_d = w_y_n[9:0];
            v_d = w_v_n;
          end
        end
        default: begin
          state_d = S_GROUND;
          y_d     = 10'(c_y_ground);
          v_d     = 8'sd0;
        end
      endcase
    end
  end

  // ----------------------------------------------------------- pixel path
  logic signed [10:0]  w_dx, w_dy;
  logic [10:0]         w_row;
  logic                w_inside;
  logic [ADDR_W-1:0]   addr_d;
  logic [c_col_w-1:0]  col_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                inside_q;
  logic [c_col_w-1:0]  col_q;
  logic [c_col_w-1:0]  w_bit_sel;

  always_comb begin
    w_dx     = $signed({1'b0, DrawX}) - c_x_pos;
    w_dy     = $signed({1'b0, DrawY}) - $signed({1'b0, y_q});
    w_inside = (w_dx >= 11'sd0) && (w_dx < c_w_px) &&
               (w_dy >= 11'sd0) && (w_dy < c_h_px);
    w_row    = 11'(w_dy >>> SCALE_SHIFT);
    col_d    = c_col_w'(w_dx >>> SCALE_SHIFT);
    addr_d   = w_inside ? ADDR_W'(int'(frame_q) * HEIGHT + int'(w_row))
                        : '0;
  end

  // MSB of a ROM row is the leftmost pixel
  assign w_bit_sel = c_col_w'(WIDTH - 1) - col_q;

  // ------------------------------------------------------------ registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync_q       <= 2'b00;
      space_prev_q <= 1'b0;
      state_q      <= S_GROUND;
      y_q          <= 10'(c_y_ground);
      v_q          <= 8'sd0;
      frame_q      <= 3'd0;
      cnt_q        <= '0;
      addr_q       <= '0;
      inside_q     <= 1'b0;
      col_q        <= '0;
    end else begin
      sync_q <= {sync_q[0], frame_clk};
      // Edge detector history follows Space even while frozen
      if (w_tick)
        space_prev_q <= w_space;
      state_q  <= state_d;
      y_q      <= y_d;
      v_q      <= v_d;
      frame_q  <= frame_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      inside_q <= w_inside;
      col_q    <= col_d;
    end
  end

  assign rom_addr    = addr_q;
  assign is_stickman = inside_q & rom_data[w_bit_sel];
  assign Stick_Y     = y_q;
  assign airborne    = (state_q != S_GROUND);
  assign anim_frame  = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_stickman_sprite.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stickman_sprite
//  Purpose  : Directed self-checking bench for stickman_sprite (SCALE_SHIFT=1,
//             other parameters default). Frame ticks are produced by pulsing
//             frame_clk for a few Clk cycles; a tiny combinational ROM model
//             answers rom_addr.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stickman_sprite;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       freeze = 1'b0;
  logic [9:0] DrawX = 10'd0;
  logic [9:0] DrawY = 10'd0;
  logic [6:0] rom_addr;
  logic [7:0] rom_data;
  logic       is_stickman;
  logic [9:0] Stick_Y;
  logic       airborne;
  logic [2:0] anim_frame;

  int vectors = 0;
  int miscompares = 0;

  int rise_y[10] = '{324, 315, 307, 300, 294, 289, 285, 282, 280, 279};
  int fall_y[11] = '{279, 280, 282, 285, 289, 294, 300, 307, 315, 324, 334};
  int hop_y[6]   = '{321, 322, 324, 327, 331, 334};

  stickman_sprite #(.SCALE_SHIFT(1)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .freeze     (freeze),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .is_stickman(is_stickman),
    .Stick_Y    (Stick_Y),
    .airborne   (airborne),
    .anim_frame (anim_frame)
  );

  always #10 Clk = ~Clk;

  // Frame 0 row 5 is the only shaped row; everything else is solid
  assign rom_data = (rom_addr == 7'd5) ? 8'b11000110 : 8'hFF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic pix(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(negedge Clk);
  endtask

  initial begin
    // ---------------- reset
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_y", Stick_Y, 334);
    check("rst_air", airborne, 0);
    check("rst_frame", anim_frame, 0);
    check("rst_hit", is_stickman, 0);
    check("rst_addr", rom_addr, 0);

    // ---------------- pixel path, frame 0, Y=334, scale x2
    pix(200, 344); check("pix200_addr", rom_addr, 5); check("pix200_hit", is_stickman, 1);
    pix(201, 344); check("pix201_hit", is_stickman, 1);
    pix(202, 344); check("pix202_hit", is_stickman, 1);
    pix(203, 344); check("pix203_hit", is_stickman, 1);
    DrawX = 10'd204;
    #1 check("pix_latency", is_stickman, 1);
    @(negedge Clk);
    check("pix204_addr", rom_addr, 5); check("pix204_hit", is_stickman, 0);
    pix(216, 344); check("pix216_addr", rom_addr, 0); check("pix216_hit", is_stickman, 0);
    pix(200, 333); check("pix_above_addr", rom_addr, 0); check("pix_above_hit", is_stickman, 0);
    DrawX = 10'd0;
    DrawY = 10'd0;

    // ---------------- grounded run animation
    for (int t = 1; t <= 24; t++) begin
      do_tick();
      check("anim_frame", anim_frame, (t / 6) % 4);
    end
    check("anim_y", Stick_Y, 334);

    // ---------------- freeze with Space held: nothing moves
    freeze = 1'b1;
    keycode = 8'h2C;
    for (int t = 0; t < 10; t++) begin
      do_tick();
      check("frz_y", Stick_Y, 334);
      check("frz_frame", anim_frame, 0);
      check("frz_air", airborne, 0);
    end
    freeze = 1'b0;
    // Space was already seen while frozen, so no edge now
    do_tick();
    check("unfrz_no_jump", airborne, 0);
    keycode = 8'h00;
    do_tick();

    // ---------------- full jump with Space held
    keycode = 8'h2C;
    do_tick();
    check("takeoff_y", Stick_Y, 334);
    check("takeoff_air", airborne, 1);
    check("takeoff_frame", anim_frame, 4);
    for (int i = 0; i < 10; i++) begin
      do_tick();
      check("rise_y", Stick_Y, 32'(rise_y[i]));
      check("rise_air", airborne, 1);
    end
    for (int i = 0; i < 11; i++) begin
      do_tick();
      check("fall_y", Stick_Y, 32'(fall_y[i]));
      check("fall_air", airborne, (i < 10) ? 1 : 0);
    end
    check("land_frame", anim_frame, 0);

    // ---------------- held across landing: no second jump
    do_tick();
    check("held_no_jump", airborne, 0);
    check("held_y", Stick_Y, 334);
    keycode = 8'h00;
    do_tick();
    keycode = 8'h2C;
    do_tick();
    check("rejump_air", airborne, 1);
    check("rejump_y", Stick_Y, 334);

    // ---------------- short hop: release at second rising tick
    do_tick();
    check("hop_r1", Stick_Y, 324);
    keycode = 8'h00;
    do_tick();
    check("hop_r2_clamp", Stick_Y, 322);
    do_tick();
    check("hop_r3", Stick_Y, 321);
    check("hop_r3_air", airborne, 1);
    for (int i = 0; i < 6; i++) begin
      do_tick();
      check("hop_fall_y", Stick_Y, 32'(hop_y[i]));
      check("hop_fall_air", airborne, (i < 5) ? 1 : 0);
    end

    // ---------------- reset mid-jump at Y=300
    keycode = 8'h2C;
    do_tick();
    for (int i = 0; i < 4; i++) do_tick();
    check("mid_y", Stick_Y, 300);
    DrawX = 10'd200;
    DrawY = 10'd310;
    Reset = 1'b0;
    @(negedge Clk);
    check("mid_rst_y_first", Stick_Y, 334);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("mid_rst_y", Stick_Y, 334);
    check("mid_rst_air", airborne, 0);
    check("mid_rst_frame", anim_frame, 0);
    check("mid_rst_hit", is_stickman, 0);
    // Reset cleared the Space history, so the held key now counts as a press
    do_tick();
    check("post_rst_jump", airborne, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
